uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver, 8N1, LSB first; consumes the serial line driven by the team's UART transmitter (loopback or off-chip peer).
- Recovers start bit, samples each bit at mid-period, presents a parallel byte with a one-cycle valid strobe, and flags framing errors.
- Sits between the pin (asynchronous rxd) and the byte-consuming logic, on the 10 MHz system clock.

Parameters:
- CLKS_PER_BIT, 1042, clocks per bit period (10 MHz / 9600 baud); legal range 4..65535.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this release.

Ports:
- clk  input  1  system clock, rising edge.
- rst_  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line; asynchronous to clk; idle high.
- dout  output  8  last good received byte; held until the next good frame.
- valid  output  1  one-cycle pulse: new byte on dout this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 when feature is off).
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (rst_ low, asynchronous): dout=0, valid=0, frame_err=0, parity_err=0, busy=0, both sync flops=1, state=IDLE, counters=0, shift register=0. Reset mid-frame discards the partial byte, with no strobe.
- rxd passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Baud counter is 16 bits; bit counter is 3 bits (0..7).
- IDLE: busy=0. When rxs=0, go to START with counter=0 and busy=1.
- START: count to HALF=(CLKS_PER_BIT-1)/2 (520 at default). At HALF, sample rxs:
  - rxs=0: go to DATA, counter=0, bit counter=0.
  - rxs=1 (glitch / false start): go to IDLE, busy=0, no strobe.
- DATA: count to CLKS_PER_BIT-1, then sample rxs into the shift register MSB and shift right (first bit ends in bit 0), and clear the counter. After the 8th sample, go to STOP (or PARITY when enabled).
- STOP: count to CLKS_PER_BIT-1 and sample rxs:
  - rxs=1: dout<=shift register, valid=1 for exactly one clock; go to IDLE.
  - rxs=0: frame_err=1 for one clock, dout unchanged, no valid; go to WAIT_HIGH.
- WAIT_HIGH (break / line stuck low): busy stays 1 until rxs=1, then go to IDLE. A held-low line produces exactly one frame_err, not repeated frames.
- valid and frame_err are mutually exclusive and never asserted on consecutive cycles for the same frame.
- Return to IDLE happens at mid stop bit, so a back-to-back frame starting immediately after the stop bit is caught.
- Latency: valid asserts 2 (sync) + HALF + 9*CLKS_PER_BIT + 1 clocks after the rxd falling edge, ±1 clock. That is 9901 ±1 clocks at default.
- Tolerance: a peer bit period of CLKS_PER_BIT±2% must be received correctly.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA and samples one even-parity bit at CLKS_PER_BIT-1.
  - At the stop sample of a good frame, parity_err is pulsed together with valid if the XOR of the 8 data bits and the parity bit is 1.
  - dout is still updated; the consumer decides whether to drop the byte.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state; frame is 8N1; parity_err is driven constant 0.

Test Plan:
- Reset, then a frame 0x55 at 1042 clks/bit -> exactly one valid pulse, dout=0x55, frame_err=0, valid 9901±1 clks after the start edge.
- Back-to-back frames 0xA5 then 0x3C with no idle gap, peer bit period 1043 clks -> two valid pulses, dout=0xA5 then 0x3C.
- rxd low pulse of 300 clks, then high -> no valid, no frame_err, busy returns to 0 within 525 clks of the falling edge.
- Frame 0xFF with the stop bit forced low, line then held low for 20000 clks -> single frame_err pulse, dout keeps its prior value, busy=1 until rxd rises, then 0.
- rst_ asserted at data bit 4 of 0x81, released, then a clean 0x81 -> no strobe from the aborted frame, one valid with dout=0x81.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> valid, parity_err=0; 0x07 with parity bit 0 -> valid and parity_err=1 on the same cycle.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid / frame_err strobes.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data and the stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       rxd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [15:0] LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF     = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rxs;
  logic        cnt_last;

  assign rxs      = sync2_q;
  assign cnt_last = (cnt_q == LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Re-check the line at mid start bit to reject glitches.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_last) begin
          par_bad_d = ^{shift_q, rxs};
          cnt_d     = '0;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (cnt_last) begin
          cnt_d = '0;
          if (rxs) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: stimulus pushes expected bytes into queues, a monitor pops them on strobes.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 1042;

  logic       clk;
  logic       rst_;
  logic       rxd;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  bit lat_chk = 0;

  logic [7:0] exp_q[$];
  logic       exp_perr_q[$];
  logic [7:0] exp_ferr_q[$];

  logic [7:0] mon_e;
  logic       mon_p;
  int         mon_d;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .rxd        (rxd),
    .dout       (dout),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks
  task automatic send_frame(input logic [7:0] b, input int bclks, input logic stop_v, input logic par_v);
    fall_cyc = cyc;
    rxd = 1'b0;
    repeat (bclks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bclks) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par_v;
    repeat (bclks) @(negedge clk);
`else
    if (par_v) rxd = 1'b1;
`endif
    rxd = stop_v;
    repeat (bclks) @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic perr);
    exp_q.push_back(b);
    exp_perr_q.push_back(perr);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_) begin
      if (valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid actual dout=%0h required no strobe", dout);
        end else begin
          mon_e = exp_q.pop_front();
          mon_p = exp_perr_q.pop_front();
          if (dout !== mon_e) begin
            errors++;
            $display("FAIL valid_dout actual=%0h required=%0h", dout, mon_e);
          end
          checks++;
          if (parity_err !== mon_p) begin
            errors++;
            $display("FAIL parity_err actual=%0b required=%0b", parity_err, mon_p);
          end
          checks++;
          if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL valid_with_frame_err actual=%0b required=0", frame_err);
          end
        end
        if (lat_chk) begin
          lat_chk = 0;
          mon_d = cyc - fall_cyc;
          checks++;
          if (mon_d < 9900 || mon_d > 9902) begin
            errors++;
            $display("FAIL latency actual=%0d required=9901+-1", mon_d);
          end
        end
      end
      if (frame_err && !valid) begin
        checks++;
        if (exp_ferr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err actual dout=%0h required no strobe", dout);
        end else begin
          mon_e = exp_ferr_q.pop_front();
          if (dout !== mon_e) begin
            errors++;
            $display("FAIL frame_err_dout actual=%0h required=%0h", dout, mon_e);
          end
        end
      end
      if (parity_err && !valid) begin
        checks++;
        errors++;
        $display("FAIL parity_err_without_valid actual=1 required=0");
      end
    end
  end

  // stimulus
  initial begin
    bit seen_idle;
    rxd  = 1'b1;
    rst_ = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_ = 1'b1;
    repeat (20) @(negedge clk);

    // single 0x55 frame with latency measurement
    expect_byte(8'h55, 1'b0);
    lat_chk = 1;
    send_frame(8'h55, CPB, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);

    // back-to-back frames, slow peer
    expect_byte(8'hA5, 1'b0);
    send_frame(8'hA5, CPB + 1, 1'b1, 1'b0);
    expect_byte(8'h3C, 1'b0);
    send_frame(8'h3C, CPB + 1, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);

    // 300-clock glitch: false start rejected
    fall_cyc = cyc;
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'h1);
    repeat (290) @(negedge clk);
    rxd = 1'b1;
    seen_idle = 0;
    while (!seen_idle && (cyc - fall_cyc) < 525) begin
      @(negedge clk);
      if (!busy) seen_idle = 1;
    end
    check("glitch_busy_low_by_525", 32'(seen_idle), 32'h1);
    repeat (100) @(negedge clk);

    // 0xFF with stop low, then line held low (break)
    exp_ferr_q.push_back(8'h3C);
    send_frame(8'hFF, CPB, 1'b0, 1'b0);
    repeat (20000 - CPB) @(negedge clk);
    check("break_busy_held", 32'(busy), 32'h1);
    check("break_dout_kept", 32'(dout), 32'h3C);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("break_busy_released", 32'(busy), 32'h0);
    repeat (100) @(negedge clk);

    // reset in the middle of data bit 4 of 0x81
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0) ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b0;
    repeat (500) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'h1);
    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_reset_dout", 32'(dout), 32'h00);
    check("abort_reset_busy", 32'(busy), 32'h0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (50) @(negedge clk);
    check("post_abort_busy", 32'(busy), 32'h0);
    expect_byte(8'h81, 1'b0);
    send_frame(8'h81, CPB, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    expect_byte(8'h07, 1'b0);
    send_frame(8'h07, CPB, 1'b1, 1'b1);
    expect_byte(8'h07, 1'b1);
    send_frame(8'h07, CPB, 1'b1, 1'b0);
    repeat (CPB) @(negedge clk);
`endif

    check("valid_queue_drained", 32'(exp_q.size()), 32'h0);
    check("frame_err_queue_drained", 32'(exp_ferr_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
